core_memory_stage: RTL and testbench

Memory-access stage directly downstream of the execution stage. Consumes the execution result (`ex_out`) and either passes it to write-back or uses it as a data-memory address for a load or store. Drives a request/grant/rvalid data-bus handshake through a 3-state FSM and stalls the execution stage while an access is in flight. Produces a registered write-back packet: valid, destination register, data and write enable.

---
 rtl/core_memory_stage.sv | 210 +++++++++++++++++++++
 tb/tb_core_memory_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_memory_stage.sv
`default_nettype none
// ============================================================================
// Module   : core_memory_stage
// Purpose  : Memory-access stage: passes ALU results to write-back or runs a
//            req/gnt/rvalid data-bus load/store. Optional macro:
//            CORE_MEM_MISALIGN_CHECK_EN (flag misaligned accesses).
// Revision : 1.0 - initial release
// ============================================================================
module core_memory_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ex_valid,
    output logic                      ex_ready,
    input  logic [DATA_WIDTH-1:0]     ex_out,
    input  logic [DATA_WIDTH-1:0]     ex_store_data,
    input  logic                      mem_op,
    input  logic                      mem_we,
    input  logic [1:0]                mem_size,
    input  logic                      mem_unsigned,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
    input  logic                      rd_we,
    output logic                      dmem_req,
    input  logic                      dmem_gnt,
    output logic [DATA_WIDTH-1:0]     dmem_addr,
    output logic                      dmem_we,
    output logic [3:0]                dmem_be,
    output logic [DATA_WIDTH-1:0]     dmem_wdata,
    input  logic                      dmem_rvalid,
    input  logic [DATA_WIDTH-1:0]     dmem_rdata,
    output logic                      wb_valid,
    output logic [REG_ADDR_WIDTH-1:0] wb_rd_addr,
    output logic [DATA_WIDTH-1:0]     wb_data,
    output logic                      wb_we,
    output logic                      misaligned_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_WAIT_RD = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                      w_accept;
    logic                      w_misaligned;
    logic                      w_req;
    logic [DATA_WIDTH-1:0]     w_addr_eff;
    logic [3:0]                w_be;
    logic [DATA_WIDTH-1:0]     w_wdata;
    logic [DATA_WIDTH-1:0]     w_rd_shifted;
    logic [DATA_WIDTH-1:0]     w_load_data;

    logic [DATA_WIDTH-1:0]     r_addr;
    logic [1:0]                r_size;
    logic                      r_unsigned;
    logic                      r_we;
    logic [REG_ADDR_WIDTH-1:0] r_rd;
    logic                      r_rd_we;
    logic [3:0]                r_be;
    logic [DATA_WIDTH-1:0]     r_wdata;

    logic                      r_wb_valid;
    logic [REG_ADDR_WIDTH-1:0] r_wb_rd;
    logic [DATA_WIDTH-1:0]     r_wb_data;
    logic                      r_wb_we;
    logic                      r_mis_err;

    assign ex_ready = (r_state == S_IDLE);
    assign w_accept = ex_valid && ex_ready;
    assign w_req    = (r_state == S_REQ);

`ifdef CORE_MEM_MISALIGN_CHECK_EN
    always_comb begin
        w_misaligned = 1'b0;
        case (mem_size)
            2'b00:   w_misaligned = 1'b0;
            2'b01:   w_misaligned = ex_out[0];
            default: w_misaligned = |ex_out[1:0];
        endcase
    end
    assign w_addr_eff = ex_out;
`else
    assign w_misaligned = 1'b0;
    // Without checking, the address is silently aligned to the access size.
    always_comb begin
        w_addr_eff = ex_out;
        case (mem_size)
            2'b00:   w_addr_eff = ex_out;
            2'b01:   w_addr_eff[0] = 1'b0;
            default: w_addr_eff[1:0] = 2'b00;
        endcase
    end
`endif

    always_comb begin
        w_be    = 4'hF;
        w_wdata = ex_store_data;
        case (mem_size)
            2'b00: begin
                w_be    = 4'b0001 << w_addr_eff[1:0];
                w_wdata = {4{ex_store_data[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << {w_addr_eff[1], 1'b0};
                w_wdata = {2{ex_store_data[15:0]}};
            end
            default: begin
                w_be    = 4'hF;
                w_wdata = ex_store_data;
            end
        endcase
    end

    assign w_rd_shifted = dmem_rdata >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_load_data = w_rd_shifted;
        case (r_size)
            2'b00:   w_load_data = {{24{~r_unsigned & w_rd_shifted[7]}}, w_rd_shifted[7:0]};
            2'b01:   w_load_data = {{16{~r_unsigned & w_rd_shifted[15]}}, w_rd_shifted[15:0]};
            default: w_load_data = w_rd_shifted;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept && mem_op && !w_misaligned) w_state_next = S_REQ;
            S_REQ:     if (dmem_gnt) w_state_next = r_we ? S_IDLE : S_WAIT_RD;
            S_WAIT_RD: if (dmem_rvalid) w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_we       <= 1'b0;
            r_rd       <= '0;
            r_rd_we    <= 1'b0;
            r_be       <= 4'b0000;
            r_wdata    <= '0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_wb_we    <= 1'b0;
            r_mis_err  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wb_valid <= 1'b0;
            r_mis_err  <= 1'b0;
            if (w_accept) begin
                if (!mem_op) begin
                    r_wb_valid <= 1'b1;
                    r_wb_data  <= ex_out;
                    r_wb_we    <= rd_we;
                    r_wb_rd    <= rd_addr;
                end else if (w_misaligned) begin
                    r_wb_valid <= 1'b1;
                    r_wb_we    <= 1'b0;
                    r_wb_rd    <= rd_addr;
                    r_mis_err  <= 1'b1;
                end else begin
                    r_addr     <= w_addr_eff;
                    r_size     <= mem_size;
                    r_unsigned <= mem_unsigned;
                    r_we       <= mem_we;
                    r_rd       <= rd_addr;
                    r_rd_we    <= rd_we;
                    r_be       <= w_be;
                    r_wdata    <= w_wdata;
                end
            end
            if (w_req && dmem_gnt && r_we) begin
                r_wb_valid <= 1'b1;
                r_wb_we    <= 1'b0;
                r_wb_rd    <= r_rd;
            end
            if ((r_state == S_WAIT_RD) && dmem_rvalid) begin
                r_wb_valid <= 1'b1;
                r_wb_we    <= r_rd_we;
                r_wb_rd    <= r_rd;
                r_wb_data  <= w_load_data;
            end
        end
    end

    // Bus outputs are zero outside a request so the idle bus is quiet.
    assign dmem_req   = w_req;
    assign dmem_addr  = w_req ? {r_addr[DATA_WIDTH-1:2], 2'b00} : '0;
    assign dmem_we    = w_req & r_we;
    assign dmem_be    = w_req ? r_be : 4'b0000;
    assign dmem_wdata = w_req ? r_wdata : '0;

    assign wb_valid       = r_wb_valid;
    assign wb_rd_addr     = r_wb_rd;
    assign wb_data        = r_wb_data;
    assign wb_we          = r_wb_we;
    assign misaligned_err = r_mis_err;

endmodule
`default_nettype wire

// File: tb/tb_core_memory_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_memory_stage
// Purpose  : Directed + randomized bench for core_memory_stage against a
//            transaction-level model of pending access and write-back packets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_memory_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [31:0] ex_out = '0;
    logic [31:0] ex_store_data = '0;
    logic        mem_op = 1'b0;
    logic        mem_we = 1'b0;
    logic [1:0]  mem_size = 2'b00;
    logic        mem_unsigned = 1'b0;
    logic [4:0]  rd_addr = '0;
    logic        rd_we = 1'b0;
    logic        dmem_req;
    logic        dmem_gnt = 1'b0;
    logic [31:0] dmem_addr;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        wb_valid;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_data;
    logic        wb_we;
    logic        misaligned_err;

    core_memory_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_out(ex_out),
        .ex_store_data(ex_store_data), .mem_op(mem_op), .mem_we(mem_we),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned),
        .rd_addr(rd_addr), .rd_we(rd_we),
        .dmem_req(dmem_req), .dmem_gnt(dmem_gnt), .dmem_addr(dmem_addr),
        .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
        .wb_we(wb_we), .misaligned_err(misaligned_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Pending bus access (one at most) and expected write-back packet.
    bit          pend = 0, granted = 0;
    logic [31:0] p_addr, p_data;
    int          p_nb;
    bit          p_store, p_uns, p_rd_we;
    logic [4:0]  p_rd;
    bit          e_valid = 0, e_err = 0, e_chk = 0, e_we = 0;
    logic [31:0] e_data;
    logic [4:0]  e_rd;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int nbytes(logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [3:0] m_be(int nb, logic [31:0] a);
        logic [3:0] r = 4'b0000;
        int off = int'(a % 4);
        for (int i = 0; i < 4; i++) if (i >= off && i < off + nb) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] m_wdata(int nb, logic [31:0] d);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % nb) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(int nb, logic [31:0] a, bit uns, logic [31:0] rd);
        logic [31:0] v = rd >> (8 * int'(a % 4));
        if (nb < 4) begin
            v = v % (32'd1 << (8 * nb));
            if (!uns && v >= (32'd1 << (8 * nb - 1))) v = v - (32'd1 << (8 * nb));
        end
        return v;
    endfunction

    // Apply the current inputs to the model, clock once, and compare.
    task automatic step();
        logic [31:0] a;
        int          nb;
        bit          mis;
        e_valid = 0; e_err = 0; e_chk = 0;
        if (rst) begin
            pend = 0; granted = 0;
        end else if (!pend) begin
            if (ex_valid && !mem_op) begin
                e_valid = 1; e_chk = 1; e_we = rd_we; e_data = ex_out; e_rd = rd_addr;
            end else if (ex_valid) begin
                a  = ex_out;
                nb = nbytes(mem_size);
`ifdef CORE_MEM_MISALIGN_CHECK_EN
                mis = (a % nb) != 0;
`else
                mis = 0;
                a   = a - (a % nb);
`endif
                if (mis) begin
                    e_valid = 1; e_err = 1; e_we = 0;
                end else begin
                    pend = 1; granted = 0; p_addr = a; p_nb = nb; p_store = mem_we;
                    p_uns = mem_unsigned; p_rd = rd_addr; p_rd_we = rd_we;
                    p_data = ex_store_data;
                end
            end
        end else if (!granted) begin
            if (dmem_gnt) begin
                if (p_store) begin
                    pend = 0; e_valid = 1; e_we = 0;
                end else granted = 1;
            end
        end else if (dmem_rvalid) begin
            pend = 0; e_valid = 1; e_chk = 1; e_we = p_rd_we; e_rd = p_rd;
            e_data = m_load(p_nb, p_addr, p_uns, dmem_rdata);
        end
        @(posedge clk);
        #1;
        chk("ex_ready", {31'd0, ex_ready}, {31'd0, !pend});
        chk("dmem_req", {31'd0, dmem_req}, {31'd0, pend && !granted});
        if (pend && !granted) begin
            chk("dmem_addr", dmem_addr, p_addr - (p_addr % 4));
            chk("dmem_we", {31'd0, dmem_we}, {31'd0, p_store});
            chk("dmem_be", {28'd0, dmem_be}, {28'd0, m_be(p_nb, p_addr)});
            if (p_store) chk("dmem_wdata", dmem_wdata, m_wdata(p_nb, p_data));
        end
        chk("wb_valid", {31'd0, wb_valid}, {31'd0, e_valid});
        if (e_valid) begin
            chk("wb_we", {31'd0, wb_we}, {31'd0, e_we});
            if (e_chk) begin
                chk("wb_data", wb_data, e_data);
                chk("wb_rd_addr", {27'd0, wb_rd_addr}, {27'd0, e_rd});
            end
        end
        chk("misaligned_err", {31'd0, misaligned_err}, {31'd0, e_err});
    endtask

    task automatic mem_issue(logic [31:0] a, bit we, logic [1:0] sz, bit uns);
        ex_valid = 1; mem_op = 1; mem_we = we; mem_size = sz; mem_unsigned = uns;
        ex_out = a; rd_addr = 5'd9; rd_we = 1;
        step();
        ex_valid = 0;
    endtask

    initial begin
        rst = 1;
        step();
        step();
        rst = 0;
        chk("reset ex_ready", {31'd0, ex_ready}, 32'd1);
        chk("reset wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("reset wb_data", wb_data, 32'd0);

        // Back-to-back non-memory ops
        ex_valid = 1; mem_op = 0; rd_we = 1; rd_addr = 5'd3;
        ex_out = 32'h11; step(); chk("b2b data0", wb_data, 32'h11);
        ex_out = 32'h22; step(); chk("b2b data1", wb_data, 32'h22);
        ex_out = 32'h33; step(); chk("b2b data2", wb_data, 32'h33);
        chk("b2b ready", {31'd0, ex_ready}, 32'd1);
        ex_valid = 0;
        step();

        // Signed then unsigned byte load from 0x1003
        for (int u = 0; u < 2; u++) begin
            mem_issue(32'h1003, 0, 2'b00, u[0]);
            chk("lb be", {28'd0, dmem_be}, 32'h8);
            chk("lb addr", dmem_addr, 32'h1000);
            dmem_gnt = 1; step(); dmem_gnt = 0;
            dmem_rvalid = 1; dmem_rdata = 32'h80FF_0000; step(); dmem_rvalid = 0;
            chk("lb data", wb_data, u ? 32'h0000_0080 : 32'hFFFF_FF80);
        end

        // Half store held off by the grant
        ex_store_data = 32'hABCD_1234;
        mem_issue(32'h2002, 1, 2'b01, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("sh req", {31'd0, dmem_req}, 32'd1);
            chk("sh addr", dmem_addr, 32'h2000);
            chk("sh be", {28'd0, dmem_be}, 32'hC);
            chk("sh wdata", dmem_wdata, 32'h1234_1234);
        end
        dmem_gnt = 1; step(); dmem_gnt = 0;
        chk("sh wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("sh wb_we", {31'd0, wb_we}, 32'd0);

        // Misaligned word load
        mem_issue(32'h3001, 0, 2'b10, 0);
`ifdef CORE_MEM_MISALIGN_CHECK_EN
        chk("mis req", {31'd0, dmem_req}, 32'd0);
        chk("mis err", {31'd0, misaligned_err}, 32'd1);
        chk("mis wb_we", {31'd0, wb_we}, 32'd0);
`else
        chk("mis addr", dmem_addr, 32'h3000);
        chk("mis be", {28'd0, dmem_be}, 32'hF);
        dmem_gnt = 1; step(); dmem_gnt = 0;
        dmem_rvalid = 1; dmem_rdata = 32'hDEAD_BEEF; step(); dmem_rvalid = 0;
        chk("mis data", wb_data, 32'hDEAD_BEEF);
`endif

        // Reset while waiting for read data, then a stray rvalid
        mem_issue(32'h4000, 0, 2'b10, 0);
        dmem_gnt = 1; step(); dmem_gnt = 0;
        rst = 1; step(); rst = 0;
        dmem_rvalid = 1; step(); dmem_rvalid = 0;
        chk("rst wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst ready", {31'd0, ex_ready}, 32'd1);
        chk("rst req", {31'd0, dmem_req}, 32'd0);

        // Stall: a held op waits for the pending load to finish
        mem_issue(32'h5000, 0, 2'b10, 0);
        ex_valid = 1; mem_op = 0; ex_out = 32'h55; rd_addr = 5'd7; rd_we = 1;
        step(); chk("stall ready", {31'd0, ex_ready}, 32'd0);
        dmem_gnt = 1; step(); dmem_gnt = 0;
        dmem_rvalid = 1; dmem_rdata = 32'h1234_5678; step(); dmem_rvalid = 0;
        chk("stall load data", wb_data, 32'h1234_5678);
        step(); chk("stall op data", wb_data, 32'h55);
        ex_valid = 0;

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            rst           = ($urandom_range(99) == 0);
            ex_valid      = ($urandom_range(3) != 0);
            mem_op        = $urandom_range(1);
            mem_we        = $urandom_range(1);
            mem_size      = 2'($urandom_range(3));
            mem_unsigned  = $urandom_range(1);
            rd_addr       = 5'($urandom);
            rd_we         = $urandom_range(1);
            ex_out        = $urandom;
            ex_store_data = $urandom;
            dmem_gnt      = ($urandom_range(2) == 0);
            dmem_rvalid   = ($urandom_range(2) == 0);
            dmem_rdata    = $urandom;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
